// File: rtl/hwpe_stream_tcdm_reader_pkg.sv
// Shared types and constants for the strided TCDM reader.
package hwpe_stream_tcdm_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } tcdm_reader_state_t;

    localparam int unsigned WORD_W  = 32;
    localparam logic [3:0]  FULL_BE = 4'hF;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_reader_if.sv
// TCDM master bundle and HWPE stream bundle used by the reader.
interface hwpe_stream_tcdm_reader_tcdm_if;
    import hwpe_stream_tcdm_reader_pkg::*;

    logic              req;
    logic              gnt;
    logic [WORD_W-1:0] add;
    logic              wen;
    logic [3:0]        be;
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] r_data;
    logic              r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_tcdm_reader_stream_if;
    import hwpe_stream_tcdm_reader_pkg::*;

    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;
    logic [3:0]        strb;

    modport master (output valid, data, strb, input ready);
    modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_reader_fifo.sv
// Response buffer: DEPTH x 32 synchronous FIFO with occupancy and flush.
module hwpe_stream_tcdm_reader_fifo
    import hwpe_stream_tcdm_reader_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WORD_W-1:0]        wdata,
    input  logic                     pop,
    output logic [WORD_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    cnt;
    logic              do_push, do_pop;

    assign full    = (cnt == (PTR_W + 1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    // A push at full is only accepted together with a pop.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    no_push_into_full: assert property (
        @(posedge clk_i) disable iff (rst_i) !(push && full && !pop && !flush)
    );

endmodule

// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM load unit returning read data as an in-order 32-bit stream.
module hwpe_stream_tcdm_reader
    import hwpe_stream_tcdm_reader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clear_i,
    input  logic                              start_i,
    input  logic [WORD_W-1:0]                 base_addr_i,
    input  logic [WORD_W-1:0]                 stride_i,
    input  logic [CNT_WIDTH-1:0]              len_i,
    output logic                              busy_o,
    output logic                              done_o,
    hwpe_stream_tcdm_reader_tcdm_if.master    tcdm,
    hwpe_stream_tcdm_reader_stream_if.master  stream
);
    localparam int unsigned OCNT_W = occ_width(FIFO_DEPTH);
    localparam logic [OCNT_W:0] CREDITS = (OCNT_W + 1)'(FIFO_DEPTH);

    tcdm_reader_state_t   state_q, state_d;
    logic [WORD_W-1:0]    addr_q, stride_q;
    logic [CNT_WIDTH-1:0] len_q, issued_q;
    logic [OCNT_W-1:0]    outstanding_q, discard_q;
    logic                 zero_done_q;

    logic [OCNT_W-1:0]    fifo_count;
    logic                 fifo_full, fifo_empty;
    logic [OCNT_W:0]      credit_used;
    logic                 start_ok, launch, grant, beat_keep, beat_drop;
    logic                 last_grant, drain_done, pop;

    assign start_ok    = start_i && !clear_i && (state_q == IDLE) && (discard_q == '0);
    assign launch      = start_ok && (len_i != '0);
    assign credit_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign grant       = tcdm.req && tcdm.gnt;
    assign beat_drop   = tcdm.r_valid && (discard_q != '0);
    assign beat_keep   = tcdm.r_valid && (discard_q == '0);
    assign last_grant  = grant && (issued_q == len_q - CNT_WIDTH'(1));
    assign drain_done  = (outstanding_q == '0) && fifo_empty;
    assign pop         = stream.valid && stream.ready;

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; clear returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (launch)     state_d = REQ;
                REQ:     if (last_grant) state_d = DRAIN;
                DRAIN:   if (drain_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs; request only while the buffer can absorb every reply in flight.
    always_comb begin
        tcdm.req = (state_q == REQ) && (credit_used < CREDITS);
        busy_o   = (state_q != IDLE);
        done_o   = zero_done_q || ((state_q == DRAIN) && drain_done);
    end

    // Transfer parameters, address accumulator and issued-word counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_ok && (len_i == '0);
            if (clear_i) begin
                issued_q <= '0;
            end else if (launch) begin
                addr_q   <= base_addr_i;
                stride_q <= stride_i;
                len_q    <= len_i;
                issued_q <= '0;
            end else if (grant) begin
                addr_q   <= addr_q + stride_q;
                issued_q <= issued_q + 1'b1;
            end
        end
    end

    // Reads in flight, and replies still owed to a cleared transfer.
    // A grant landing in the clear cycle is also owed a reply, so it joins the discard count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (clear_i) begin
            outstanding_q <= '0;
            discard_q     <= outstanding_q + discard_q + OCNT_W'(grant) - OCNT_W'(tcdm.r_valid);
        end else begin
            outstanding_q <= outstanding_q + OCNT_W'(grant) - OCNT_W'(beat_keep);
            if (beat_drop) discard_q <= discard_q - 1'b1;
        end
    end

    hwpe_stream_tcdm_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (clear_i),
        .push  (beat_keep),
        .wdata (tcdm.r_data),
        .pop   (pop),
        .rdata (stream.data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign stream.valid = !fifo_empty;
    assign stream.strb  = FULL_BE;
    assign tcdm.add     = addr_q;
    assign tcdm.wen     = 1'b1;
    assign tcdm.be      = FULL_BE;
    assign tcdm.data    = '0;

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Directed bench for the strided TCDM reader with a memory/scoreboard model.
module tb_hwpe_stream_tcdm_reader;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic          clk;
    logic          rst;
    logic          clear;
    logic          start;
    logic [31:0]   base;
    logic [31:0]   stride;
    logic [CW-1:0] len;
    logic          busy;
    logic          done;

    hwpe_stream_tcdm_reader_tcdm_if   tcdm_bus ();
    hwpe_stream_tcdm_reader_stream_if stream_bus ();

    hwpe_stream_tcdm_reader #(
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .start_i     (start),
        .base_addr_i (base),
        .stride_i    (stride),
        .len_i       (len),
        .busy_o      (busy),
        .done_o      (done),
        .tcdm        (tcdm_bus.master),
        .stream      (stream_bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Memory model: content of a word is a fixed function of its address.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [31:0] grant_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] resp_addr_q[$];
    int          resp_due_q[$];

    int   cyc         = 0;
    int   lat         = 1;
    bit   gnt_rand    = 0;
    bit   rdy_rand    = 0;
    bit   rdy_fix     = 0;
    int   gnt_limit   = 0;
    int   grants_live = 0;
    int   pops_live   = 0;
    int   done_cnt    = 0;
    bit   mon_en      = 0;

    bit          prev_wait  = 0;
    logic [31:0] prev_add   = '0;
    bit          prev_sv    = 0;
    logic [31:0] prev_sd    = '0;
    bit          prev_done  = 0;

    // TCDM slave, stream sink and per-cycle compare against the model.
    initial begin
        tcdm_bus.gnt      = 1'b0;
        tcdm_bus.r_valid  = 1'b0;
        tcdm_bus.r_data   = '0;
        stream_bus.ready  = 1'b0;
        forever begin
            @(negedge clk);
            tcdm_bus.gnt = ((gnt_limit == 0) || (grants_live < gnt_limit)) &&
                           (gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
            stream_bus.ready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
            if (resp_due_q.size() > 0 && resp_due_q[0] == cyc) begin
                tcdm_bus.r_valid = 1'b1;
                tcdm_bus.r_data  = mem_rd(resp_addr_q[0]);
                resp_due_q.delete(0);
                resp_addr_q.delete(0);
            end else begin
                tcdm_bus.r_valid = 1'b0;
                tcdm_bus.r_data  = 32'hDEAD_BEEF;
            end
            #4;
            if (mon_en) begin
                chk1("tcdm_wen", tcdm_bus.wen, 1'b1);
                chk("tcdm_be", 32'(tcdm_bus.be), 32'hF);
                chk("tcdm_wdata", tcdm_bus.data, 32'h0);
                if (prev_wait) begin
                    chk1("req_held", tcdm_bus.req, 1'b1);
                    chk("add_held", tcdm_bus.add, prev_add);
                end
                prev_wait = tcdm_bus.req && !tcdm_bus.gnt && !clear;
                prev_add  = tcdm_bus.add;
                if (tcdm_bus.req && tcdm_bus.gnt) begin
                    grant_log.push_back(tcdm_bus.add);
                    resp_addr_q.push_back(tcdm_bus.add);
                    resp_due_q.push_back(cyc + lat);
                    grants_live++;
                    chk1("grant_expected", exp_addr_q.size() != 0, 1'b1);
                    if (exp_addr_q.size() != 0) chk("grant_addr", tcdm_bus.add, exp_addr_q.pop_front());
                end
                chk1("credit_limit", (grants_live - pops_live) <= int'(DEPTH), 1'b1);
                if (prev_sv) begin
                    chk1("valid_held", stream_bus.valid, 1'b1);
                    chk("data_held", stream_bus.data, prev_sd);
                end
                prev_sv = stream_bus.valid && !stream_bus.ready && !clear;
                prev_sd = stream_bus.data;
                if (stream_bus.valid) begin
                    chk("stream_strb", 32'(stream_bus.strb), 32'hF);
                    chk1("valid_expected", exp_data_q.size() != 0, 1'b1);
                    if (stream_bus.ready && exp_data_q.size() != 0) begin
                        chk("stream_data", stream_bus.data, exp_data_q.pop_front());
                        pop_log.push_back(stream_bus.data);
                        pops_live++;
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk1("done_single", prev_done, 1'b0);
                end
                prev_done = done;
            end
            cyc++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic setup();
        grant_log.delete();
        pop_log.delete();
        grants_live = 0;
        pops_live   = 0;
    endtask

    task automatic start_xfer(input logic [31:0] b, input logic [31:0] s,
                              input logic [CW-1:0] l, input bit accept);
        logic [31:0] a;
        tick();
        base   = b;
        stride = s;
        len    = l;
        start  = 1'b1;
        if (accept) begin
            for (int unsigned i = 0; i < 32'(l); i++) begin
                a = b + i * s;
                exp_addr_q.push_back(a);
                exp_data_q.push_back(mem_rd(a));
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic finish_xfer(input int d0, input logic [CW-1:0] l, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk1("done_seen", done_cnt != d0, 1'b1);
        chk1("busy_after", busy, 1'b0);
        chk1("done_after", done, 1'b0);
        chk("done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("grant_total", 32'(grant_log.size()), 32'(l));
        chk("pop_total", 32'(pop_log.size()), 32'(l));
        chk("model_drained", 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] s,
                       input logic [CW-1:0] l, input int budget);
        int d0;
        d0 = done_cnt;
        setup();
        start_xfer(b, s, l, 1'b1);
        finish_xfer(d0, l, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0;
        int n;
        rst    = 1'b1;
        clear  = 1'b0;
        start  = 1'b0;
        base   = '0;
        stride = '0;
        len    = '0;
        repeat (3) tick();
        chk1("rst_req", tcdm_bus.req, 1'b0);
        chk("rst_add", tcdm_bus.add, 32'h0);
        chk1("rst_valid", stream_bus.valid, 1'b0);
        chk("rst_data", stream_bus.data, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        rst    = 1'b0;
        mon_en = 1;
        rdy_fix = 1;
        tick();

        // 1: unit stride, one-cycle latency, sink always ready.
        lat = 1;
        run(32'h1000, 32'd4, 16'd8, 200);
        chk("t1_first_addr", grant_log[0], 32'h0000_1000);
        chk("t1_last_addr", grant_log[7], 32'h0000_101C);
        chk("t1_first_word", pop_log[0], 32'h5A5A_1000);
        chk("t1_last_word", pop_log[7], 32'h5A5A_101C);

        // 2: negative stride wrapping below zero.
        run(32'h10, 32'hFFFF_FFF8, 16'd4, 200);
        chk("t2_addr1", grant_log[1], 32'h0000_0008);
        chk("t2_addr2", grant_log[2], 32'h0000_0000);
        chk("t2_addr3", grant_log[3], 32'hFFFF_FFF8);
        chk("t2_word3", pop_log[3], 32'hA5A5_FFF8);

        // 3: stalled sink limits reads to the buffer depth.
        rdy_fix = 0;
        d0 = done_cnt;
        setup();
        start_xfer(32'h4000, 32'd4, 16'd10, 1'b1);
        repeat (30) tick();
        chk("t3_grants_stalled", 32'(grant_log.size()), 32'd4);
        chk1("t3_req_low", tcdm_bus.req, 1'b0);
        chk1("t3_valid", stream_bus.valid, 1'b1);
        chk("t3_head", stream_bus.data, 32'h5A5A_4000);
        rdy_fix = 1;
        finish_xfer(d0, 16'd10, 300);

        // 4: random grant and sink, three-cycle latency.
        lat      = 3;
        gnt_rand = 1;
        rdy_rand = 1;
        run(32'h2000, 32'd12, 16'd16, 1500);
        gnt_rand = 0;
        rdy_rand = 0;

        // 5a: zero-length start completes at once without requests.
        d0 = done_cnt;
        setup();
        start_xfer(32'h7000, 32'd4, 16'd0, 1'b0);
        chk1("t5_zero_done", done, 1'b1);
        chk1("t5_zero_busy", busy, 1'b0);
        chk1("t5_zero_req", tcdm_bus.req, 1'b0);
        tick();
        chk1("t5_zero_done_gone", done, 1'b0);
        chk("t5_zero_pulses", 32'(done_cnt - d0), 32'd1);
        chk("t5_zero_grants", 32'(grant_log.size()), 32'd0);

        // 5b: a start while busy leaves the running sequence untouched.
        lat = 2;
        d0  = done_cnt;
        setup();
        start_xfer(32'h3000, 32'd4, 16'd6, 1'b1);
        tick();
        chk1("t5_busy", busy, 1'b1);
        start_xfer(32'h9000, 32'd4, 16'd3, 1'b0);
        finish_xfer(d0, 16'd6, 300);

        // 6: clear with two reads in flight; their replies must vanish.
        lat       = 6;
        gnt_limit = 2;
        setup();
        start_xfer(32'h5000, 32'd4, 16'd8, 1'b1);
        n = 0;
        while (grant_log.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6_grants_before_clear", 32'(grant_log.size()), 32'd2);
        clear = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        grants_live = 0;
        pops_live   = 0;
        tick();
        clear = 1'b0;
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_valid", stream_bus.valid, 1'b0);
        chk1("t6_req", tcdm_bus.req, 1'b0);
        repeat (12) tick();
        chk("t6_late_beats_sent", 32'(resp_due_q.size()), 32'd0);
        chk1("t6_valid_after_drop", stream_bus.valid, 1'b0);
        gnt_limit = 0;
        run(32'h6000, 32'd4, 16'd4, 200);
        chk("t6_new_first", pop_log[0], 32'h5A5A_6000);
        chk("t6_new_last", pop_log[3], 32'h5A5A_600C);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
